branch_flag_sequencer: RTL and testbench
========================================

// Module: branch_flag_sequencer
// PURPOSE
//  Sequences the flag register and resolves conditional branches against it.
//  - Sits between decode and the flag register.
//  - Accepts one op at a time and generates the flag register's write-enable.
//  - Evaluates each branch condition code against the registered Low/Negative/Zero flags.
//  - Presents the taken/not-taken result to fetch with a valid/ack handshake.
//  - Counts taken branches for the performance counters.
// PARAMETERS
//  CNT_W   16   width of taken-branch counter (wraps)
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  op_valid       in   1      decode presents an op
//  op_ready       out  1      sequencer can accept an op (IDLE only)
//  op_sets_flags  in   1      accepted op writes the flag register
//  op_is_branch   in   1      accepted op is a conditional branch
//  op_cond        in   4      branch condition code (table below)
//  flag_low       in   1      registered Low flag from flag register
//  flag_neg       in   1      registered Negative flag
//  flag_zero      in   1      registered Zero flag
//  flag_we        out  1      write-enable to flag register
//  branch_valid   out  1      branch result valid to fetch
//  branch_taken   out  1      result: 1 = redirect, 0 = fall through
//  branch_ack     in   1      fetch consumed result
//  flush          in   1      kill any in-flight branch
//  taken_count    out  CNT_W  count of acknowledged taken branches
// BEHAVIOUR
//  Reset (reset=0, async):
//  - state=IDLE.
//  - flag_we, op_ready, branch_valid, branch_taken = 0; taken_count = 0.
//  - Outputs stay 0 for as long as reset is held low.
//  Accept:
//  - accept = op_valid & op_ready.
//  - flag_we = accept & op_sets_flags, combinational, same cycle.
//  - So the flag register updates at the same edge that accepts the op.
//  FSM:
//  - IDLE:
//    - op_ready=1.
//    - accept & op_is_branch: latch op_cond, go to EVAL.
//    - otherwise stay.
//  - EVAL:
//    - op_ready=0.
//    - Evaluate the latched cond on the flag_* inputs.
//    - Register the result into branch_taken; go to RESOLVE.
//  - RESOLVE:
//    - op_ready=0, branch_valid=1.
//    - branch_taken is held stable until branch_ack.
//    - On branch_ack: go to IDLE; if taken, taken_count += 1 (wraps at 2^CNT_W).
//  Latency:
//  - Branch accepted in cycle N; flags sampled in N+1; branch_valid high from N+2.
//  - Minimum branch occupancy is 3 cycles.
//  Combined op (op_sets_flags & op_is_branch together):
//  - flag_we pulses in the accept cycle.
//  - EVAL sees the NEW flags; no stall is needed.
//  Condition table (op_cond):
//  - 0 EQ: Z
//  - 1 NE: !Z
//  - 2 LO: L
//  - 3 HS: !L
//  - 4 LT: N
//  - 5 GE: !N
//  - 6 LS: L|Z
//  - 7 HI: !L&!Z
//  - 8 LE: N|Z
//  - 9 GT: !N&!Z
//  - 14 UC: 1
//  - 15 NV: 0
//  - 10-13: reserved, evaluate to 0
//  flush:
//  - In EVAL or RESOLVE: next state IDLE, branch_valid and branch_taken cleared, counter unchanged.
//  - flush together with branch_ack: flush wins, no count.
//  - flush in IDLE: does not block an accept in the same cycle.
//  Back-pressure:
//  - branch_ack low holds RESOLVE indefinitely; op_ready stays 0.
//  Reset mid-operation:
//  - Immediate return to IDLE and all outputs cleared.
//  - An already-pulsed flag_we is not undone.
// TESTING
//  1. Reset, then release: op_ready=1, taken_count=0, branch_valid=0; hold reset low mid-RESOLVE -> branch_valid drops to 0 asynchronously.
//  2. Op with sets_flags=1 and ALU Z=1, then EQ branch: flag_we=1 for 1 cycle; branch_valid at +2 cycles, taken=1; ack -> taken_count=1.
//  3. Combined op (sets_flags, is_branch, cond=NE) with new Z=0 and old Z=1 -> taken=1, proving the new flags are used.
//  4. All 16 op_cond values over all 8 flag combinations -> taken matches the table; cond 10-13 and 15 are never taken.
//  5. Branch in RESOLVE, branch_ack held low for 5 cycles -> op_ready=0 and taken stable; flush+ack in one cycle -> IDLE, count unchanged.
//  6. CNT_W=2: five taken-and-acknowledged branches -> taken_count=1 (wrap).

Source files
------------

// File: rtl/branch_flag_sequencer.sv
// Branch/flag sequencer: generates the flag register write-enable for accepted
// ops, resolves conditional branches against the registered L/N/Z flags, hands
// the result to fetch, and counts acknowledged taken branches.
//
// Handshakes:
//   op_valid/op_ready : an op transfers in any cycle where both are high
//                       (op_ready is high only in IDLE and never during reset).
//   branch_valid/branch_ack : the result transfers in any cycle where both
//                       are high; branch_taken is held stable while
//                       branch_valid is high and ack is low. flush overrides ack.
module branch_flag_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_sets_flags,
  input  logic             op_is_branch,
  input  logic [3:0]       op_cond,
  input  logic             flag_low,
  input  logic             flag_neg,
  input  logic             flag_zero,
  output logic             flag_we,
  output logic             branch_valid,
  output logic             branch_taken,
  input  logic             branch_ack,
  input  logic             flush,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EVAL    = 2'd1;
  localparam logic [1:0] S_RESOLVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cond_q, cond_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             cond_hit;

  // op_ready is gated by reset so it reads 0 while reset is held low.
  assign op_ready     = reset & (state_q == S_IDLE);
  assign accept       = op_valid & op_ready;
  // Same-cycle write-enable: the flag register updates on the accepting edge,
  // so a combined op's EVAL cycle already sees the new flags.
  assign flag_we      = accept & op_sets_flags;
  assign branch_valid = (state_q == S_RESOLVE);
  assign branch_taken = taken_q;
  assign taken_count  = cnt_q;
  assign dbg_state    = state_q;

  // Condition decode of the latched code against the live flag inputs.
  always_comb begin
    cond_hit = 1'b0;
    case (cond_q)
      4'd0:    cond_hit = flag_zero;
      4'd1:    cond_hit = ~flag_zero;
      4'd2:    cond_hit = flag_low;
      4'd3:    cond_hit = ~flag_low;
      4'd4:    cond_hit = flag_neg;
      4'd5:    cond_hit = ~flag_neg;
      4'd6:    cond_hit = flag_low | flag_zero;
      4'd7:    cond_hit = ~flag_low & ~flag_zero;
      4'd8:    cond_hit = flag_neg | flag_zero;
      4'd9:    cond_hit = ~flag_neg & ~flag_zero;
      4'd14:   cond_hit = 1'b1;
      default: cond_hit = 1'b0; // 10-13 reserved, 15 never
    endcase
  end

  // Next-state, result and counter logic.
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        taken_d = 1'b0;
        // flush does not block an accept while idle.
        if (accept && op_is_branch) begin
          cond_d  = op_cond;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (flush) begin
          state_d = S_IDLE;
          taken_d = 1'b0;
        end else begin
          taken_d = cond_hit;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (flush) begin
          // flush beats a simultaneous ack: no count.
          state_d = S_IDLE;
          taken_d = 1'b0;
        end else if (branch_ack) begin
          state_d = S_IDLE;
          taken_d = 1'b0;
          if (taken_q) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        taken_d = 1'b0;
      end
    endcase
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cond_q  <= 4'd0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_flag_sequencer.sv
// Directed bench for branch_flag_sequencer. A second instance with CNT_W=2
// shares all inputs so counter wrap is observed alongside the 16-bit count.
module tb_branch_flag_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_sets_flags;
  logic        op_is_branch;
  logic [3:0]  op_cond;
  logic        flag_low, flag_neg, flag_zero;
  logic        branch_ack;
  logic        flush;

  logic        op_ready, flag_we, branch_valid, branch_taken;
  logic [15:0] taken_count;
  logic [1:0]  dbg_state;
  logic        op_ready2, flag_we2, branch_valid2, branch_taken2;
  logic [1:0]  taken_count2;
  logic [1:0]  dbg_state2;

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_cnt;

  // observations captured by drive_branch
  logic        obs_rdy_acc, obs_we_acc, obs_we_eval, obs_rdy_eval, obs_v_eval;
  logic        obs_v_res, obs_tk, obs_v_after, obs_rdy_after;

  // hand-computed truth masks: bit index = {L,N,Z}
  logic [7:0]  cond_mask [16];

  branch_flag_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_sets_flags(op_sets_flags), .op_is_branch(op_is_branch), .op_cond(op_cond),
    .flag_low(flag_low), .flag_neg(flag_neg), .flag_zero(flag_zero),
    .flag_we(flag_we), .branch_valid(branch_valid), .branch_taken(branch_taken),
    .branch_ack(branch_ack), .flush(flush), .taken_count(taken_count),
    .dbg_state(dbg_state)
  );

  branch_flag_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready2),
    .op_sets_flags(op_sets_flags), .op_is_branch(op_is_branch), .op_cond(op_cond),
    .flag_low(flag_low), .flag_neg(flag_neg), .flag_zero(flag_zero),
    .flag_we(flag_we2), .branch_valid(branch_valid2), .branch_taken(branch_taken2),
    .branch_ack(branch_ack), .flush(flush), .taken_count(taken_count2),
    .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 0; op_sets_flags = 0; op_is_branch = 0; op_cond = 4'd0;
    branch_ack = 0; flush = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    #1;
    exp_cnt = 16'd0;
  endtask

  // Driver: one branch from accept to ack (no flush); records observations.
  task automatic drive_branch(input logic sets, input logic [3:0] cond,
                              input logic [2:0] fl_acc, input logic [2:0] fl_eval);
    op_valid = 1; op_is_branch = 1; op_sets_flags = sets; op_cond = cond;
    {flag_low, flag_neg, flag_zero} = fl_acc;
    #1;
    obs_rdy_acc = op_ready; obs_we_acc = flag_we;
    tick();
    op_valid = 0; op_is_branch = 0; op_sets_flags = 0;
    {flag_low, flag_neg, flag_zero} = fl_eval;
    #1;
    obs_we_eval = flag_we; obs_rdy_eval = op_ready; obs_v_eval = branch_valid;
    tick();
    obs_v_res = branch_valid; obs_tk = branch_taken;
    branch_ack = 1;
    tick();
    branch_ack = 0;
    #1;
    obs_v_after = branch_valid; obs_rdy_after = op_ready;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    flag_low = 0; flag_neg = 0; flag_zero = 0;
    tick();
    n_cmp++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL reset_op_ready_held got=%b exp=0", op_ready); end
    reset = 1;
    #2;
    exp_cnt = 16'd0;
    n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    n_cmp++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", taken_count); end
    n_cmp++; if (branch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", branch_valid); end
    // take an unconditional branch into RESOLVE, then assert reset mid-cycle
    op_valid = 1; op_is_branch = 1; op_cond = 4'd14;
    tick();
    op_valid = 0; op_is_branch = 0;
    tick();
    n_cmp++; if (branch_valid !== 1'b1 || branch_taken !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_resolve got=%b%b exp=11", branch_valid, branch_taken); end
    op_valid = 1; op_sets_flags = 1;
    reset = 0;
    #1;
    n_cmp++; if (branch_valid !== 1'b0) begin n_err++; $display("FAIL reset_async_valid got=%b exp=0", branch_valid); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_async_taken got=%b exp=0", branch_taken); end
    n_cmp++; if (op_ready !== 1'b0 || flag_we !== 1'b0) begin
      n_err++; $display("FAIL reset_async_ready_we got=%b%b exp=00", op_ready, flag_we); end
    idle_inputs();
    tick();
    reset = 1;
    #1;
    n_cmp++; if (op_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_release got=%b/%0d exp=1/0", op_ready, dbg_state); end
  endtask

  task automatic test_flag_then_eq();
    // flag-setting ALU op; the ALU result has Z=1
    op_valid = 1; op_sets_flags = 1; op_is_branch = 0;
    #1;
    n_cmp++; if (flag_we !== 1'b1) begin n_err++; $display("FAIL alu_flag_we got=%b exp=1", flag_we); end
    tick();
    op_valid = 0; op_sets_flags = 0;
    {flag_low, flag_neg, flag_zero} = 3'b001;
    #1;
    n_cmp++; if (flag_we !== 1'b0 || op_ready !== 1'b1) begin
      n_err++; $display("FAIL alu_after got=we%b rdy%b exp=we0 rdy1", flag_we, op_ready); end
    drive_branch(1'b0, 4'd0, 3'b001, 3'b001);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (obs_we_acc !== 1'b0) begin n_err++; $display("FAIL eq_we got=%b exp=0", obs_we_acc); end
    n_cmp++; if (obs_rdy_eval !== 1'b0 || obs_v_eval !== 1'b0) begin
      n_err++; $display("FAIL eq_eval got=rdy%b v%b exp=rdy0 v0", obs_rdy_eval, obs_v_eval); end
    n_cmp++; if (obs_v_res !== 1'b1 || obs_tk !== 1'b1) begin
      n_err++; $display("FAIL eq_resolve got=v%b t%b exp=v1 t1", obs_v_res, obs_tk); end
    n_cmp++; if (obs_v_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
      n_err++; $display("FAIL eq_after_ack got=v%b rdy%b exp=v0 rdy1", obs_v_after, obs_rdy_after); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_err++; $display("FAIL eq_count got=%0d exp=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_combined();
    // old Z=1 at accept, new Z=0 visible in EVAL: NE must be taken
    drive_branch(1'b1, 4'd1, 3'b001, 3'b000);
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (obs_we_acc !== 1'b1 || obs_rdy_acc !== 1'b1) begin
      n_err++; $display("FAIL comb_we got=we%b rdy%b exp=we1 rdy1", obs_we_acc, obs_rdy_acc); end
    n_cmp++; if (obs_we_eval !== 1'b0) begin n_err++; $display("FAIL comb_we_pulse got=%b exp=0", obs_we_eval); end
    n_cmp++; if (obs_tk !== 1'b1) begin n_err++; $display("FAIL comb_taken got=%b exp=1", obs_tk); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_err++; $display("FAIL comb_count got=%0d exp=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_cond_table();
    logic [3:0] c;
    logic [2:0] f;
    logic       e;
    for (int ci = 0; ci < 16; ci++) begin
      for (int fi = 0; fi < 8; fi++) begin
        c = 4'(ci);
        f = 3'(fi);
        e = cond_mask[ci][fi];
        drive_branch(1'b0, c, ~f, f);
        if (e) exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (obs_v_res !== 1'b1 || obs_tk !== e) begin
          n_err++; $display("FAIL cond_%0d_flags_%b got=v%b t%b exp=v1 t%b", ci, f, obs_v_res, obs_tk, e); end
      end
    end
    n_cmp++; if (taken_count !== exp_cnt) begin n_err++; $display("FAIL cond_count got=%0d exp=%0d", taken_count, exp_cnt); end
    n_cmp++; if (taken_count2 !== exp_cnt[1:0]) begin n_err++; $display("FAIL cond_count2 got=%0d exp=%0d", taken_count2, exp_cnt[1:0]); end
  endtask

  task automatic test_back_pressure_flush();
    op_valid = 1; op_is_branch = 1; op_cond = 4'd14;
    tick();
    op_valid = 0; op_is_branch = 0;
    tick();
    // hold ack low; decode keeps offering a flag-setting op
    op_valid = 1; op_sets_flags = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (op_ready !== 1'b0 || flag_we !== 1'b0 || branch_valid !== 1'b1 || branch_taken !== 1'b1) begin
        n_err++; $display("FAIL bp_hold_%0d got=rdy%b we%b v%b t%b exp=rdy0 we0 v1 t1", i, op_ready, flag_we, branch_valid, branch_taken); end
      tick();
    end
    op_valid = 0; op_sets_flags = 0;
    flush = 1; branch_ack = 1;
    tick();
    flush = 0; branch_ack = 0;
    #1;
    n_cmp++; if (branch_valid !== 1'b0 || branch_taken !== 1'b0 || op_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_flush got=v%b t%b rdy%b exp=v0 t0 rdy1", branch_valid, branch_taken, op_ready); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_err++; $display("FAIL bp_flush_count got=%0d exp=%0d", taken_count, exp_cnt); end
    // flush in IDLE does not block an accept; flush in EVAL cancels
    flush = 1; op_valid = 1; op_is_branch = 1; op_cond = 4'd14;
    tick();
    op_valid = 0; op_is_branch = 0;
    #1;
    n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL flush_idle_accept got=%0d exp=1", dbg_state); end
    tick();
    flush = 0;
    #1;
    n_cmp++; if (branch_valid !== 1'b0 || op_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_eval got=v%b rdy%b exp=v0 rdy1", branch_valid, op_ready); end
    n_cmp++; if (taken_count !== exp_cnt) begin n_err++; $display("FAIL flush_eval_count got=%0d exp=%0d", taken_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_branch(1'b0, 4'd14, 3'b000, 3'b000);
    end
    n_cmp++; if (taken_count2 !== 2'd1) begin n_err++; $display("FAIL wrap_cnt2 got=%0d exp=1", taken_count2); end
    n_cmp++; if (taken_count !== 16'd5) begin n_err++; $display("FAIL wrap_cnt16 got=%0d exp=5", taken_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 16'd0;
    cond_mask[0]  = 8'hAA; cond_mask[1]  = 8'h55;
    cond_mask[2]  = 8'hF0; cond_mask[3]  = 8'h0F;
    cond_mask[4]  = 8'hCC; cond_mask[5]  = 8'h33;
    cond_mask[6]  = 8'hFA; cond_mask[7]  = 8'h05;
    cond_mask[8]  = 8'hEE; cond_mask[9]  = 8'h11;
    cond_mask[10] = 8'h00; cond_mask[11] = 8'h00;
    cond_mask[12] = 8'h00; cond_mask[13] = 8'h00;
    cond_mask[14] = 8'hFF; cond_mask[15] = 8'h00;
    test_reset();
    test_flag_then_eq();
    test_combined();
    test_cond_table();
    test_back_pressure_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
